// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hold/flush controller for the five-stage datapath.
// Resolves mem_wait > branch_taken > stall into PC/pipeline-register write
// enables and flushes (Mealy), tracks hazard history in a 2-bit state, and
// keeps saturating performance counters plus sticky debug flags.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   RUN    | last cycle advanced normally
//   BUBBLE | last cycle held PC/IF_ID and inserted a bubble into ID_EXE
//   FLUSH  | last cycle redirected the PC and flushed IF_ID/ID_EXE/EXE_MEM
//   FREEZE | last cycle held the whole pipeline for data memory
module hazard_ctrl #(
  parameter int CNT_W    = 16,
  parameter int WAIT_MAX = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic             mem_wait,
  input  logic             clr_cnt,
  output logic             PC_Wr,
  output logic             IF_ID_Wr,
  output logic             ID_EXE_Wr,
  output logic             EXE_MEM_Wr,
  output logic             MEM_WB_Wr,
  output logic             IF_ID_Flush,
  output logic             ID_EXE_Flush,
  output logic             EXE_MEM_Flush,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] freeze_cnt,
  output logic             hazard_err,
  output logic             mem_timeout
);

  localparam logic [1:0] ST_RUN    = 2'b00;
  localparam logic [1:0] ST_BUBBLE = 2'b01;
  localparam logic [1:0] ST_FLUSH  = 2'b10;
  localparam logic [1:0] ST_FREEZE = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [7:0]       WAIT_LIM = 8'(WAIT_MAX);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic [CNT_W-1:0] r_freeze_cnt;
  logic [7:0]       r_wait;
  logic             r_hazard_err;
  logic             r_mem_timeout;

  logic       w_freeze;
  logic       w_redirect;
  logic       w_bubble;
  logic [1:0] w_next_state;
  logic [7:0] w_wait_inc;

  // Priority resolution of the hazard sources for this cycle.
  always_comb begin
    w_freeze   = mem_wait;
    w_redirect = !mem_wait && branch_taken;
    w_bubble   = !mem_wait && !branch_taken && stall;
    w_wait_inc = (r_wait == 8'hFF) ? r_wait : r_wait + 8'd1;
  end

  // Mealy control outputs and next-state selection; all quiet while in reset.
  always_comb begin
    PC_Wr         = 1'b0;
    IF_ID_Wr      = 1'b0;
    ID_EXE_Wr     = 1'b0;
    EXE_MEM_Wr    = 1'b0;
    MEM_WB_Wr     = 1'b0;
    IF_ID_Flush   = 1'b0;
    ID_EXE_Flush  = 1'b0;
    EXE_MEM_Flush = 1'b0;
    w_next_state  = ST_RUN;
    if (w_freeze) begin
      w_next_state = ST_FREEZE;
    end else if (w_redirect) begin
      w_next_state = ST_FLUSH;
    end else if (w_bubble) begin
      w_next_state = ST_BUBBLE;
    end
    if (rst_n && !w_freeze) begin
      // Enables stay high with a flush so the bubble is actually loaded.
      PC_Wr         = !w_bubble;
      IF_ID_Wr      = !w_bubble;
      ID_EXE_Wr     = 1'b1;
      EXE_MEM_Wr    = 1'b1;
      MEM_WB_Wr     = 1'b1;
      IF_ID_Flush   = w_redirect;
      ID_EXE_Flush  = w_redirect || w_bubble;
      EXE_MEM_Flush = w_redirect;
    end
  end

  // Hazard-history state; clr_cnt deliberately leaves it alone.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Saturating event counters, clear wins over increment.
  always_ff @(posedge clk) begin
    if (!rst_n || clr_cnt) begin
      r_stall_cnt  <= '0;
      r_flush_cnt  <= '0;
      r_freeze_cnt <= '0;
    end else begin
      if (w_bubble && r_stall_cnt != CNT_MAX) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (w_redirect && r_flush_cnt != CNT_MAX) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
      if (w_freeze && r_freeze_cnt != CNT_MAX) begin
        r_freeze_cnt <= r_freeze_cnt + 1'b1;
      end
    end
  end

  // Consecutive freeze-cycle counter; any cycle without mem_wait leaves FREEZE.
  always_ff @(posedge clk) begin
    if (!rst_n || clr_cnt) begin
      r_wait <= '0;
    end else if (w_freeze) begin
      r_wait <= w_wait_inc;
    end else begin
      r_wait <= '0;
    end
  end

  // Sticky debug flags: a second back-to-back bubble, or a freeze that ran
  // for WAIT_MAX consecutive cycles.
  always_ff @(posedge clk) begin
    if (!rst_n || clr_cnt) begin
      r_hazard_err  <= 1'b0;
      r_mem_timeout <= 1'b0;
    end else begin
      if (w_bubble && r_state == ST_BUBBLE) begin
        r_hazard_err <= 1'b1;
      end
      if (w_freeze && w_wait_inc >= WAIT_LIM) begin
        r_mem_timeout <= 1'b1;
      end
    end
  end

  // Register outputs.
  always_comb begin
    state       = r_state;
    stall_cnt   = r_stall_cnt;
    flush_cnt   = r_flush_cnt;
    freeze_cnt  = r_freeze_cnt;
    hazard_err  = r_hazard_err;
    mem_timeout = r_mem_timeout;
  end

endmodule
